// File: rtl/sum_accumulator.sv
// Sequential accumulator that sums a group of 16-bit operands through an external
// combinational adder, tracking sticky carry/overflow and a saturating operand count.
module sum_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_cin,
    input  logic [15:0]      add_s,
    input  logic             add_cout,
    output logic [15:0]      out_data,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SUM  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [15:0]      acc_r;
    logic [15:0]      op_r;
    logic             last_r;
    logic             carry_r;
    logic             ovf_r;
    logic [CNT_W-1:0] count_r;
    logic             in_ready_r;
    logic             out_valid_r;

    // Two's-complement overflow: operands share a sign that the sum does not.
    function automatic logic signed_ovf(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] s);
        return (a[15] == b[15]) && (s[15] != a[15]);
    endfunction

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = SUM;
                else          state_s = IDLE;
            end
            SUM: begin
                if (last_r) state_s = DONE;
                else        state_s = IDLE;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Datapath: capture operand in IDLE, fold adder result in SUM, clear on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= 16'h0000;
            op_r    <= 16'h0000;
            last_r  <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            count_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= in_data;
                        last_r <= in_last;
                    end
                end
                SUM: begin
                    acc_r   <= add_s;
                    carry_r <= carry_r | add_cout;
                    ovf_r   <= ovf_r | signed_ovf(acc_r, op_r, add_s);
                    if (count_r != {CNT_W{1'b1}}) begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_r   <= 16'h0000;
                        carry_r <= 1'b0;
                        ovf_r   <= 1'b0;
                        count_r <= '0;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign add_a     = acc_r;
    assign add_b     = op_r;
    assign add_cin   = 1'b0;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = acc_r;
    assign out_carry = carry_r;
    assign out_ovf   = ovf_r;
    assign out_count = count_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: two accumulators (CNT_W=8 and CNT_W=2) driven in lockstep,
// each with its own behavioural adder.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready1, in_ready2;
    logic [15:0] add_a1, add_b1, add_s1, add_a2, add_b2, add_s2;
    logic        add_cin1, add_cout1, add_cin2, add_cout2;
    logic [15:0] out_data1, out_data2;
    logic        out_carry1, out_carry2, out_ovf1, out_ovf2;
    logic [7:0]  out_count1;
    logic [1:0]  out_count2;
    logic        out_valid1, out_valid2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {16'h0000, add_cin1};
    assign {add_cout2, add_s2} = {1'b0, add_a2} + {1'b0, add_b2} + {16'h0000, add_cin2};

    sum_accumulator #(.CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready1), .add_a(add_a1), .add_b(add_b1),
        .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1),
        .out_data(out_data1), .out_carry(out_carry1), .out_ovf(out_ovf1),
        .out_count(out_count1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    sum_accumulator #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready2), .add_a(add_a2), .add_b(add_b2),
        .add_cin(add_cin2), .add_s(add_s2), .add_cout(add_cout2),
        .out_data(out_data2), .out_carry(out_carry2), .out_ovf(out_ovf2),
        .out_count(out_count2), .out_valid(out_valid2), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hs(input string tag, input logic rdy, input logic vld);
        chk({tag, "_in_ready1"}, {31'd0, in_ready1}, {31'd0, rdy});
        chk({tag, "_out_valid1"}, {31'd0, out_valid1}, {31'd0, vld});
        chk({tag, "_in_ready2"}, {31'd0, in_ready2}, {31'd0, rdy});
        chk({tag, "_out_valid2"}, {31'd0, out_valid2}, {31'd0, vld});
    endtask

    task automatic chk_res(input string tag, input logic [15:0] d, input logic c,
                           input logic o, input logic [7:0] n1, input logic [1:0] n2);
        chk({tag, "_data1"}, {16'd0, out_data1}, {16'd0, d});
        chk({tag, "_carry1"}, {31'd0, out_carry1}, {31'd0, c});
        chk({tag, "_ovf1"}, {31'd0, out_ovf1}, {31'd0, o});
        chk({tag, "_count1"}, {24'd0, out_count1}, {24'd0, n1});
        chk({tag, "_data2"}, {16'd0, out_data2}, {16'd0, d});
        chk({tag, "_count2"}, {30'd0, out_count2}, {30'd0, n2});
    endtask

    // Starts and ends just after a falling edge; last operands land in DONE.
    task automatic send(input logic [15:0] d, input logic l);
        chk_hs("pre_send", 1'b1, 1'b0);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_hs("sum_state", 1'b0, 1'b0);
        chk("add_cin", {31'd0, add_cin1}, 32'd0);
        chk("add_b", {16'd0, add_b1}, {16'd0, d});
        @(negedge clk);
        if (l) chk_hs("done_state", 1'b0, 1'b1);
        else   chk_hs("idle_state", 1'b1, 1'b0);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_hs("after_take", 1'b1, 1'b0);
        chk_res("cleared", 16'h0000, 1'b0, 1'b0, 8'd0, 2'd0);
    endtask

    initial begin
        #12;
        chk_hs("reset", 1'b1, 1'b0);
        chk_res("reset", 16'h0000, 1'b0, 1'b0, 8'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
        chk_res("sum123", 16'h0006, 1'b0, 1'b0, 8'd3, 2'd3);
        take();

        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
        chk_res("carry", 16'h0001, 1'b1, 1'b0, 8'd2, 2'd2);
        take();

        send(16'h7FFF, 1'b0);
        send(16'h0001, 1'b1);
        chk_res("ovf", 16'h8000, 1'b0, 1'b1, 8'd2, 2'd2);
        take();

        // Held result with the consumer stalled and stray operands offered.
        send(16'h1234, 1'b1);
        in_data  = 16'hAAAA;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_hs("stall", 1'b0, 1'b1);
            chk_res("stall", 16'h1234, 1'b0, 1'b0, 8'd1, 2'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take();
        send(16'h0010, 1'b1);
        chk_res("fresh_group", 16'h0010, 1'b0, 1'b0, 8'd1, 2'd1);
        take();

        // Asynchronous reset in the middle of a group.
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        chk_res("partial", 16'h0300, 1'b0, 1'b0, 8'd2, 2'd2);
        in_data  = 16'h0400;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_hs("async_rst", 1'b1, 1'b0);
        chk_res("async_rst", 16'h0000, 1'b0, 1'b0, 8'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_hs("post_rst", 1'b1, 1'b0);
        @(negedge clk);
        chk_hs("post_rst2", 1'b1, 1'b0);
        send(16'h0005, 1'b1);
        chk_res("after_rst", 16'h0005, 1'b0, 1'b0, 8'd1, 2'd1);
        take();

        // Five operands: narrow counter saturates at 3.
        for (int i = 0; i < 4; i++) send(16'h0001, 1'b0);
        send(16'h0001, 1'b1);
        chk_res("saturate", 16'h0005, 1'b0, 1'b0, 8'd5, 2'd3);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter CNT_W, default 8: width of the operand counter.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_data  in  16  operand.
REQ-005 in_valid  in  1  operand valid.
REQ-006 in_last  in  1  final operand of the group; qualified by in_valid.
REQ-007 in_ready  out  1  block accepts an operand this cycle.
REQ-008 add_a  out  16  to adder A: accumulator register.
REQ-009 add_b  out  16  to adder B: registered operand.
REQ-010 add_cin  out  1  to adder cin: constant 0.
REQ-011 add_s  in  16  from adder S.
REQ-012 add_cout  in  1  from adder cout.
REQ-013 out_data  out  16  accumulated sum.
REQ-014 out_carry  out  1  sticky unsigned carry-out flag.
REQ-015 out_ovf  out  1  sticky signed-overflow flag.
REQ-016 out_count  out  CNT_W  operands summed.
REQ-017 out_valid  out  1  result valid.
REQ-018 out_ready  in  1  consumer accepts result.

Function
REQ-019 FSM states SHALL be IDLE, SUM and DONE. A transfer SHALL occur on any cycle where valid and ready are both high.
REQ-020 IDLE: in_ready=1 and out_valid=0.
REQ-021 IDLE, on in_valid:
- op_q <= in_data; last_q <= in_last.
- Transition to SUM.
REQ-022 SUM: in_ready=0.
REQ-023 SUM, single cycle:
- acc <= add_s; carry <= carry | add_cout.
- ovf <= ovf | (acc[15]==op_q[15] & add_s[15]!=acc[15]).
- count <= count+1, saturating at 2^CNT_W-1.
- Next state DONE if last_q, else IDLE.
REQ-024 The adder SHALL be purely combinational. add_a and add_b SHALL be driven only from acc and op_q. add_s SHALL be sampled only in SUM.
REQ-025 DONE: out_valid=1; out_data, out_carry, out_ovf and out_count SHALL hold register values stable until accepted; in_ready=0.
REQ-026 DONE, on out_ready:
- acc, carry, ovf and count SHALL clear to 0.
- Transition to IDLE.
- The next operand SHALL be accepted no earlier than the following cycle.
REQ-027 Throughput SHALL be one operand per 2 cycles. Latency from accepting the last operand to out_valid SHALL be 2 cycles.
REQ-028 In DONE with out_ready low, in_valid SHALL be ignored and no state SHALL change.
REQ-029 A group of one operand (in_last on the first operand) SHALL yield out_data equal to that operand and out_count=1.
REQ-030 In SUM and DONE, in_valid and in_last SHALL be don't-care.

Reset
REQ-031 While rst_n=0, independent of clk:
- State SHALL be IDLE.
- acc, op_q, last_q, carry, ovf and count SHALL be 0.
- out_valid=0 and in_ready=1 immediately.
REQ-032 Reset asserted in SUM or DONE SHALL discard the partial group. No out_valid SHALL appear for that group.

Verification
REQ-033 Operands 0x0001, 0x0002, 0x0003 (last) -> out_data=0x0006, out_count=3, out_carry=0, out_ovf=0, out_valid 2 cycles after the last accept.
REQ-034 Operands 0xFFFF, 0x0002 (last) -> out_data=0x0001, out_carry=1, out_ovf=0.
REQ-035 Operands 0x7FFF, 0x0001 (last) -> out_data=0x8000, out_ovf=1, out_carry=0.
REQ-036 Single operand 0x1234 with in_last; out_ready held low 5 cycles -> outputs stable, in_ready=0, extra in_valid ignored; then out_ready=1 -> IDLE, next group starts from acc=0.
REQ-037 rst_n pulsed low mid-group after 2 operands -> in_ready=1, out_valid=0 asynchronously; a new group 0x0005 (last) -> out_data=0x0005, out_count=1.
REQ-038 CNT_W=2, five operands of 0x0001 -> out_data=0x0005, out_count=3 (saturated).
